// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 hash core and its downstream stages.
//   SHA256_DIGEST_BITS : width of a full digest (H0..H7 packed).
//   SHA256_H_INIT      : initial hash value H0..H7, H0 in the top word.
//   ser_state_t        : state encoding of the digest serializer.
// -----------------------------------------------------------------------------
package sha256_pkg;

  localparam int SHA256_DIGEST_BITS = 256;

  localparam logic [SHA256_DIGEST_BITS-1:0] SHA256_H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/sha256_pend_slot.sv
// -----------------------------------------------------------------------------
// sha256_pend_slot
// One-entry holding register for a digest that arrives while the serializer
// is busy. Load and take may coincide: the reader gets the old contents this
// cycle and the new digest is kept, so the slot stays full.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_load     : write i_data into the slot, marks it full
//   i_take     : reader consumes the slot contents this cycle
//   i_data     : digest to store
//   o_data     : stored digest (qualified by o_full)
//   o_full     : slot holds a digest
// -----------------------------------------------------------------------------
module sha256_pend_slot
  import sha256_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_load,
  input  logic                          i_take,
  input  logic [SHA256_DIGEST_BITS-1:0] i_data,
  output logic [SHA256_DIGEST_BITS-1:0] o_data,
  output logic                          o_full
);

  logic [SHA256_DIGEST_BITS-1:0] r_data;
  logic                          r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; r_full alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/sha256_digest_serializer.sv
// -----------------------------------------------------------------------------
// sha256_digest_serializer
// Captures a 256-bit SHA-256 digest on a single-cycle digest_valid pulse and
// streams it out as WORD_BITS-wide words over valid/ready, H0 first.
//
// Compile-time option SHA256_SER_PENDING_EN:
//   defined   : a digest arriving mid-transfer is parked in a one-entry slot
//               and sent right after the current one; a further arrival while
//               the slot is full is dropped and sets overrun.
//   undefined : any digest arriving mid-transfer (other than on the last-word
//               handshake) is dropped and sets overrun.
//
// Ports:
//   clk, reset    : clock and asynchronous active-low reset
//   digest_valid  : one-cycle pulse qualifying digest
//   digest        : H0..H7 packed, H0 in [255:224]
//   out_ready     : consumer accepts out_data
//   out_valid     : out_data holds a valid word
//   out_data      : current word
//   out_last      : final word of a digest
//   busy          : a digest is being sent or one is parked
//   overrun       : sticky, a digest was dropped
//   overrun_clr   : synchronous clear of overrun (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module sha256_digest_serializer
  import sha256_pkg::*;
#(
  parameter int WORD_BITS   = 32,
  parameter int DIGEST_BITS = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   digest_valid,
  input  logic [DIGEST_BITS-1:0] digest,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WORD_BITS-1:0]   out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int NWORDS = SHA256_DIGEST_BITS / WORD_BITS;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  generate
    if ((SHA256_DIGEST_BITS % WORD_BITS) != 0) begin : g_bad_word_bits
      $error("WORD_BITS must divide 256 evenly");
    end
    if (DIGEST_BITS != SHA256_DIGEST_BITS) begin : g_bad_digest_bits
      $error("DIGEST_BITS must be 256");
    end
  endgenerate

  ser_state_t                    r_state;
  logic [SHA256_DIGEST_BITS-1:0] r_shift;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_overrun;

  logic                          w_hs;
  logic                          w_last_hs;
  logic                          w_reload;       // another digest follows the last word
  logic [SHA256_DIGEST_BITS-1:0] w_reload_data;
  logic                          w_overrun_set;

  assign out_valid = (r_state == SEND);
  assign out_data  = r_shift[SHA256_DIGEST_BITS-1 -: WORD_BITS];
  assign out_last  = (r_state == SEND) && (r_cnt == LAST_CNT);
  assign overrun   = r_overrun;

  assign w_hs      = out_valid && out_ready;
  assign w_last_hs = w_hs && (r_cnt == LAST_CNT);

`ifdef SHA256_SER_PENDING_EN
  logic                          w_pend_full;
  logic                          w_pend_load;
  logic                          w_pend_take;
  logic [SHA256_DIGEST_BITS-1:0] w_pend_data;

  // Mid-transfer arrivals fill an empty slot. On the last-word handshake a
  // full slot is drained into the shifter, and a coincident arrival refills it;
  // with the slot empty that arrival goes straight to the shifter instead.
  assign w_pend_load   = digest_valid && (r_state == SEND) &&
                         (w_last_hs ? w_pend_full : !w_pend_full);
  assign w_pend_take   = w_last_hs && w_pend_full;
  assign w_overrun_set = digest_valid && (r_state == SEND) && !w_last_hs && w_pend_full;
  assign w_reload      = w_pend_full || digest_valid;
  assign w_reload_data = w_pend_full ? w_pend_data : digest;
  assign busy          = (r_state == SEND) || w_pend_full;

  sha256_pend_slot u_pend_slot (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_pend_load),
    .i_take (w_pend_take),
    .i_data (digest),
    .o_data (w_pend_data),
    .o_full (w_pend_full)
  );
`else
  assign w_overrun_set = digest_valid && (r_state == SEND) && !w_last_hs;
  assign w_reload      = digest_valid;
  assign w_reload_data = digest;
  assign busy          = (r_state == SEND);
`endif

  // The shifter is reset so out_data reads zero after reset. On the final
  // handshake it is not shifted, so out_data keeps the last word while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (digest_valid) begin
            r_shift <= digest;
            r_cnt   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_last_hs) begin
            if (w_reload) begin
              r_shift <= w_reload_data;
              r_cnt   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_hs) begin
            r_shift <= r_shift << WORD_BITS;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

endmodule

// File: doc/sha256_digest_serializer.md
# sha256_digest_serializer

Downstream stage of the SHA-256 hash core: captures the 256-bit digest when the core signals completion and streams it out as WORD_BITS-wide words over a valid/ready handshake, most-significant word (H0) first. It decouples the core's single-cycle `done` pulse from a narrower, possibly stalling consumer such as a host bus or UART bridge. Digests arriving while a transfer is in progress are either queued or flagged as overruns, selected at compile time.

## Interface
- `WORD_BITS`, 32, output word width; must divide 256 evenly (8, 16, 32, 64, 128, 256 are legal).
- `DIGEST_BITS`, 256, digest width; fixed at 256, parameter exists only for width checks.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `digest_valid`  in  1  one-cycle pulse; `digest` is valid in that cycle.
- `digest`  in  256  H0..H7 packed, H0 in [255:224].
- `out_ready`  in  1  consumer accepts `out_data` when high with `out_valid`.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_data`  out  WORD_BITS  current word.
- `out_last`  out  1  high with `out_valid` on the final word of a digest.
- `busy`  out  1  a digest is being sent, or one is queued.
- `overrun`  out  1  sticky: a digest was dropped.
- `overrun_clr`  in  1  synchronous clear of `overrun`.

## Operation
- NWORDS = 256 / WORD_BITS. A word counter runs 0..NWORDS-1, and a shift register holds the digest.
- States: IDLE, SEND.
- IDLE: on `digest_valid`, load the shift register, clear the counter, and go to SEND.
- SEND: `out_valid`=1 and `out_data` = shift register [255 -: WORD_BITS]. On handshake (`out_valid & out_ready`), shift left by WORD_BITS and increment the counter.
  - `out_last`=1 when counter = NWORDS-1.
  - On the handshake of the last word, go to IDLE, unless a new digest is available (see below).
- Stall: while `out_ready`=0, `out_data`, `out_last` and the counter hold. `out_valid` never drops mid-digest.
- Simultaneous last-word handshake and `digest_valid`: capture the new digest directly. Stay in SEND with the counter at 0; `out_valid` stays high with no bubble.
- `digest_valid` in SEND, not on a last-word handshake: handled per Configuration.
- `overrun_clr` and a new overrun event in the same cycle: the set wins.
- `busy` = (state == SEND) | pending_full.

## Timing
- Reset (asynchronous assert, synchronous deassert by the integrator): state IDLE, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `overrun`=0, pending empty.
- Latency: `digest_valid` in cycle N gives `out_valid`=1 with word 0 in cycle N+1.
- Full throughput: with `out_ready` held high, one word per cycle. A digest occupies NWORDS cycles (8 at default).
- Reset asserted mid-transfer: outputs return to reset values immediately; the partial digest and any queued digest are discarded.
- When `out_valid`=0, `out_data` holds its last value and is don't-care to the consumer.

## Configuration
- `SHA256_SER_PENDING_EN` defined: adds a one-entry pending slot.
  - A `digest_valid` in SEND with the slot empty stores the digest in the slot.
  - On the next last-word handshake, the slot loads into the shift register and sending continues with no bubble; the slot empties.
  - A `digest_valid` while the slot is full drops that digest and sets `overrun`.
  - On the last-word handshake with the slot full and `digest_valid` both present: the slot digest is sent next, and the incoming digest is written into the slot.
- Not defined: any `digest_valid` in SEND that is not on a last-word handshake is dropped and sets `overrun`. Pending logic is absent and `busy` = (state == SEND).

## Structure
- Shared package `sha256_pkg` holds:
  - `ser_state_t` enum {IDLE, SEND};
  - localparam `SHA256_DIGEST_BITS` = 256;
  - the H0 initial-value constant, if not already present.
- Compile-time assertion that 256 % WORD_BITS == 0.
- One sub-module is natural: `sha256_pend_slot` (256-bit register with full flag, load and take strobes), instantiated only under `SHA256_SER_PENDING_EN`. The shifter and counter stay inline.

## Test plan
- Reset, then `digest`=SHA-256("abc") (ba7816bf 8f01cfea … f20015ad) with `out_ready`=1. Required: 8 words ba7816bf … f20015ad on consecutive cycles starting the cycle after the pulse; `out_last` only on f20015ad; then IDLE with `busy`=0.
- Same digest with `out_ready` toggling 1,0,0,1 repeating. Required: words in order with none duplicated or skipped; `out_data` stable during stalls.
- Two digests, the second's pulse coincident with the last-word handshake of the first. Required: 16 contiguous valid cycles and `out_last` twice.
- Second digest pulsed at word 3 of the first.
  - Macro off: `overrun`=1 and only the first digest is output.
  - Macro on: both digests are output back-to-back.
  - Macro on, plus a third digest pulsed while the slot is full: `overrun`=1, and the third digest is never output.
- `reset` asserted low at word 5 with `out_ready`=0. Required: `out_valid`, `out_last`, `busy` and `overrun` go to 0 without waiting for a clock edge; after release, no stale words are output.
- WORD_BITS=64 build. Required: 4 words ba7816bf8f01cfea … with `out_last` on the 4th.
